move_segmenter: RTL and testbench

Upstream motion stage feeding the two axis stepper controllers (X and Y). It accepts one relative move (dx, dy) over a valid/ready handshake. Because each controller takes a signed step count of only COUNT_BITS, it splits the move into 2^k equal-proportion segments. For each segment it triggers both axes together and waits until both report done.

---
 rtl/motion_pkg.sv | 24 ++
 rtl/move_segmenter_if.sv | 30 +++
 rtl/move_segmenter_fsm.sv | 57 +++++
 rtl/move_segmenter.sv | 129 ++++++++++++
 tb/tb_move_segmenter.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/motion_pkg.sv
// Shared motion definitions: segmenter state encoding, step-range helper and
// signed-to-magnitude conversion used by the move segmenter.
package motion_pkg;

  localparam int BYTE_BITS = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    ISSUE = 2'd2,
    WAIT  = 2'd3
  } seg_state_t;

  // Largest magnitude a signed count of count_bits can carry.
  function automatic int max_step(input int count_bits);
    return (1 << (count_bits - 1)) - 1;
  endfunction

  // Callers sign-extend into 64 bits and truncate the result to their width.
  function automatic logic [63:0] mag_of(input logic signed [63:0] v);
    return v[63] ? $unsigned(-v) : $unsigned(v);
  endfunction

endpackage

// File: rtl/move_segmenter_if.sv
// Command and axis-controller signals of the move segmenter, grouped so the
// motion stage and its environment share one bundle.
interface move_segmenter_if #(
  parameter int COUNT_BITS = motion_pkg::BYTE_BITS,
  parameter int DELTA_BITS = 16
);
  // Handshake: a command transfers in the cycle where cmd_valid & cmd_ready;
  // cmd_ready is high only while idle, and nothing is buffered while busy.
  logic                          clk_en;
  logic                          cmd_valid;
  logic signed [DELTA_BITS-1:0]  cmd_dx;
  logic signed [DELTA_BITS-1:0]  cmd_dy;
  logic                          cmd_ready;
  logic                          trigger;
  logic signed [COUNT_BITS-1:0]  num_steps_x;
  logic signed [COUNT_BITS-1:0]  num_steps_y;
  logic                          done_x;
  logic                          done_y;
  logic                          busy;

  modport master (
    output clk_en, cmd_valid, cmd_dx, cmd_dy, done_x, done_y,
    input  cmd_ready, trigger, num_steps_x, num_steps_y, busy
  );

  modport slave (
    input  clk_en, cmd_valid, cmd_dx, cmd_dy, done_x, done_y,
    output cmd_ready, trigger, num_steps_x, num_steps_y, busy
  );
endinterface

// File: rtl/move_segmenter_fsm.sv
// Sequencing for the move segmenter: state register plus registered
// cmd_ready / busy / trigger derived from the next state.
module move_segmenter_fsm
  import motion_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       clk_en,
  input  logic       cmd_valid,
  input  logic       cmd_zero,
  input  logic       calc_fit,
  input  logic       last_seg,
  input  logic       done_x,
  input  logic       done_y,
  output seg_state_t state_o,
  output logic       cmd_ready_o,
  output logic       busy_o,
  output logic       trigger_o
);

  seg_state_t state_q, state_d;
  logic       cmd_ready_q;
  logic       busy_q;
  logic       trigger_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cmd_valid && !cmd_zero) state_d = CALC;
      CALC:    if (calc_fit) state_d = ISSUE;
      ISSUE:   if (clk_en) state_d = WAIT;
      WAIT:    if (done_x && done_y) state_d = last_seg ? IDLE : ISSUE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from state_d so they line up with the state they describe.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cmd_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      trigger_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= (state_d == IDLE);
      busy_q      <= (state_d != IDLE);
      trigger_q   <= (state_d == ISSUE);
    end
  end

  assign state_o     = state_q;
  assign cmd_ready_o = cmd_ready_q;
  assign busy_o      = busy_q;
  assign trigger_o   = trigger_q;

endmodule

// File: rtl/move_segmenter.sv
// Splits a relative (dx, dy) move into 2^k equal-proportion segments whose
// per-axis step counts fit the stepper controllers' signed count width.
module move_segmenter
  import motion_pkg::*;
#(
  parameter int COUNT_BITS = BYTE_BITS,
  parameter int DELTA_BITS = 16,
  parameter int K_BITS     = $clog2(DELTA_BITS) + 1
) (
  input  logic                  clk,
  input  logic                  reset,
  move_segmenter_if.slave       bus,
  output seg_state_t            state_o,
  output logic [K_BITS-1:0]     k_o,
  output logic [DELTA_BITS:0]   seg_o
);

  localparam int SEG_BITS = DELTA_BITS + 1;
  localparam logic [DELTA_BITS-1:0] FIT_LIMIT = DELTA_BITS'(max_step(COUNT_BITS) - 1);

  seg_state_t                   state;
  logic [DELTA_BITS-1:0]        mag_x_q, mag_y_q;
  logic                         neg_x_q, neg_y_q;
  logic [DELTA_BITS-1:0]        q_x_q, q_y_q, r_x_q, r_y_q;
  logic [K_BITS-1:0]            k_q;
  logic [SEG_BITS-1:0]          seg_q;
  logic signed [COUNT_BITS-1:0] steps_x_q, steps_y_q;

  logic [DELTA_BITS-1:0]        in_mag_x, in_mag_y, mag_max;
  logic [DELTA_BITS-1:0]        q_x, q_y, r_x, r_y;
  logic [SEG_BITS-1:0]          seg_last;
  logic                         cmd_zero, calc_fit, last_seg;
  logic                         accept, advance;

  // The first r segments carry one extra step so the segments sum to the delta.
  function automatic logic signed [COUNT_BITS-1:0] seg_steps(
    input logic [DELTA_BITS-1:0] q,
    input logic [DELTA_BITS-1:0] r,
    input logic                  neg,
    input logic [SEG_BITS-1:0]   seg
  );
    logic [COUNT_BITS-1:0] m;
    m = COUNT_BITS'(q) + ((seg < SEG_BITS'(r)) ? COUNT_BITS'(1) : COUNT_BITS'(0));
    return neg ? -m : m;
  endfunction

  assign in_mag_x = DELTA_BITS'(mag_of(64'(bus.cmd_dx)));
  assign in_mag_y = DELTA_BITS'(mag_of(64'(bus.cmd_dy)));
  assign cmd_zero = (in_mag_x == '0) && (in_mag_y == '0);

  assign mag_max  = (mag_x_q > mag_y_q) ? mag_x_q : mag_y_q;
  assign calc_fit = (mag_max >> k_q) <= FIT_LIMIT;
  assign q_x      = mag_x_q >> k_q;
  assign q_y      = mag_y_q >> k_q;
  assign r_x      = mag_x_q - (q_x << k_q);
  assign r_y      = mag_y_q - (q_y << k_q);

  assign seg_last = (SEG_BITS'(1) << k_q) - SEG_BITS'(1);
  assign last_seg = (seg_q == seg_last);
  assign accept   = (state == IDLE) && bus.cmd_valid;
  assign advance  = (state == WAIT) && bus.done_x && bus.done_y && !last_seg;

  move_segmenter_fsm u_fsm (
    .clk        (clk),
    .reset      (reset),
    .clk_en     (bus.clk_en),
    .cmd_valid  (bus.cmd_valid),
    .cmd_zero   (cmd_zero),
    .calc_fit   (calc_fit),
    .last_seg   (last_seg),
    .done_x     (bus.done_x),
    .done_y     (bus.done_y),
    .state_o    (state),
    .cmd_ready_o(bus.cmd_ready),
    .busy_o     (bus.busy),
    .trigger_o  (bus.trigger)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mag_x_q   <= '0;
      mag_y_q   <= '0;
      neg_x_q   <= 1'b0;
      neg_y_q   <= 1'b0;
      q_x_q     <= '0;
      q_y_q     <= '0;
      r_x_q     <= '0;
      r_y_q     <= '0;
      k_q       <= '0;
      seg_q     <= '0;
      steps_x_q <= '0;
      steps_y_q <= '0;
    end else begin
      if (accept) begin
        mag_x_q <= in_mag_x;
        mag_y_q <= in_mag_y;
        neg_x_q <= bus.cmd_dx[DELTA_BITS-1];
        neg_y_q <= bus.cmd_dy[DELTA_BITS-1];
        k_q     <= '0;
        seg_q   <= '0;
      end
      if (state == CALC) begin
        if (calc_fit) begin
          q_x_q     <= q_x;
          q_y_q     <= q_y;
          r_x_q     <= r_x;
          r_y_q     <= r_y;
          steps_x_q <= seg_steps(q_x, r_x, neg_x_q, '0);
          steps_y_q <= seg_steps(q_y, r_y, neg_y_q, '0);
        end else if (k_q != '1) begin
          k_q <= k_q + K_BITS'(1);
        end
      end
      // Step counts change only between segments, never while a controller may sample them.
      if (advance) begin
        seg_q     <= seg_q + SEG_BITS'(1);
        steps_x_q <= seg_steps(q_x_q, r_x_q, neg_x_q, seg_q + SEG_BITS'(1));
        steps_y_q <= seg_steps(q_y_q, r_y_q, neg_y_q, seg_q + SEG_BITS'(1));
      end
    end
  end

  assign bus.num_steps_x = steps_x_q;
  assign bus.num_steps_y = steps_y_q;
  assign state_o         = state;
  assign k_o             = k_q;
  assign seg_o           = seg_q;

endmodule

// File: tb/tb_move_segmenter.sv
// Directed bench for move_segmenter: axis controller models, a segment
// scoreboard fed by the stimulus and drained by a trigger monitor.
module tb_move_segmenter;
  import motion_pkg::*;

  localparam int CB = 8;
  localparam int DB = 16;
  localparam int KB = $clog2(DB) + 1;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  seg_state_t     state;
  logic [KB-1:0]  k;
  logic [DB:0]    seg;

  move_segmenter_if #(.COUNT_BITS(CB), .DELTA_BITS(DB)) bus ();

  move_segmenter #(.COUNT_BITS(CB), .DELTA_BITS(DB), .K_BITS(KB)) dut (
    .clk    (clk),
    .reset  (reset),
    .bus    (bus),
    .state_o(state),
    .k_o    (k),
    .seg_o  (seg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [2*CB-1:0] exp_q[$];
  logic [2*CB-1:0] mon_exp;
  int n_checks = 0;
  int n_fail   = 0;
  int en_mode  = 0;
  logic manual_en = 1'b0;
  int en_cnt   = 0;
  int lat_x    = 2;
  int lat_y    = 3;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // clk_en: every 4th cycle, or a manual level for the hold test.
  initial begin
    bus.clk_en = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      en_cnt++;
      bus.clk_en = (en_mode != 0) ? manual_en : (en_cnt % 4 == 0);
    end
  end

  // ---------------- axis controller models ----------------
  initial begin
    bus.done_x = 1'b1;
    forever begin
      @(negedge clk);
      if (bus.trigger && bus.clk_en) begin
        bus.done_x = 1'b0;
        repeat (lat_x) @(negedge clk);
        bus.done_x = 1'b1;
      end
    end
  end

  initial begin
    bus.done_y = 1'b1;
    forever begin
      @(negedge clk);
      if (bus.trigger && bus.clk_en) begin
        bus.done_y = 1'b0;
        repeat (lat_y) @(negedge clk);
        bus.done_y = 1'b1;
      end
    end
  end

  // ---------------- monitor ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (bus.trigger && bus.clk_en) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL seg_unexpected: got x=%0d y=%0d, expected no segment",
                   bus.num_steps_x, bus.num_steps_y);
        end else begin
          mon_exp = exp_q.pop_front();
          if ({bus.num_steps_x, bus.num_steps_y} != mon_exp) begin
            n_fail++;
            $display("FAIL seg_steps: got x=%0d y=%0d, expected x=%0d y=%0d",
                     bus.num_steps_x, bus.num_steps_y,
                     $signed(mon_exp[2*CB-1:CB]), $signed(mon_exp[CB-1:0]));
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_seg(input int x, input int y, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back({CB'(x), CB'(y)});
  endtask

  task automatic send_cmd(input int dx, input int dy);
    bus.cmd_dx    = DB'(dx);
    bus.cmd_dy    = DB'(dy);
    bus.cmd_valid = 1'b1;
    tick();
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    while (bus.busy && n < budget) begin
      n++;
      tick();
    end
    check({name, " idle"}, bus.busy, 0);
    check({name, " ready"}, bus.cmd_ready, 1);
  endtask

  task automatic wait_state(input string name, input seg_state_t s, input int budget);
    int n = 0;
    while (state != s && n < budget) begin
      n++;
      tick();
    end
    check({name, " reach_state"}, state, s);
  endtask

  task automatic run_move(input string name, input int dx, input int dy, input int exp_k);
    int calc_cycles = 0;
    send_cmd(dx, dy);
    while (state == CALC && calc_cycles < 64) begin
      calc_cycles++;
      tick();
    end
    check({name, " calc_cycles"}, calc_cycles, exp_k + 1);
    check({name, " k"}, k, exp_k);
    wait_idle(name, 20000);
    check({name, " segs_left"}, exp_q.size(), 0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog expired");
  end

  // ---------------- main sequence ----------------
  initial begin
    int bad;
    bus.cmd_valid = 1'b0;
    bus.cmd_dx    = '0;
    bus.cmd_dy    = '0;
    reset         = 1'b0;
    repeat (3) tick();

    check("rst state", state, IDLE);
    check("rst trigger", bus.trigger, 0);
    check("rst busy", bus.busy, 0);
    check("rst cmd_ready", bus.cmd_ready, 1);
    check("rst steps_x", bus.num_steps_x, 0);
    check("rst steps_y", bus.num_steps_y, 0);
    check("rst k", k, 0);
    check("rst seg", seg, 0);
    reset = 1'b1;
    repeat (2) tick();

    // 300,-100: k=2, four segments of (75,-25)
    push_seg(75, -25, 4);
    run_move("m300", 300, -100, 2);
    check("m300 state", state, IDLE);

    // 301,10: remainders spread over the first segments
    push_seg(76, 3, 1);
    push_seg(75, 3, 1);
    push_seg(75, 2, 2);
    run_move("m301", 301, 10, 2);

    // zero move issues nothing
    send_cmd(0, 0);
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      if (!bus.cmd_ready || bus.busy || bus.trigger || state != IDLE) bad++;
      tick();
    end
    check("zero_cmd quiet", bad, 0);

    // most negative delta: k=9, 512 segments
    push_seg(-64, 1, 5);
    push_seg(-64, 0, 507);
    run_move("mneg", -32768, 5, 9);

    // trigger hold with clk_en low, then done_y lagging done_x
    en_mode   = 1;
    manual_en = 1'b0;
    lat_y     = 22;
    repeat (2) tick();
    push_seg(10, 10, 1);
    send_cmd(10, 10);
    wait_state("hold", ISSUE, 20);
    for (int i = 0; i < 3; i++) begin
      check("hold trigger", bus.trigger, 1);
      check("hold steps_x", bus.num_steps_x, 10);
      tick();
    end
    manual_en = 1'b1;
    tick();
    check("hold trigger_at_en", bus.trigger, 1);
    manual_en = 1'b0;
    tick();
    check("hold trigger_after_en", bus.trigger, 0);
    check("hold state_wait", state, WAIT);
    bad = 0;
    while (!bus.done_x && bad < 10) begin
      bad++;
      tick();
    end
    check("hold done_x_back", bus.done_x, 1);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (state != WAIT || bus.trigger) bad++;
      tick();
    end
    check("hold no_advance", bad, 0);
    bad = 0;
    while (!bus.done_y && bad < 30) begin
      bad++;
      tick();
    end
    check("hold done_y_back", bus.done_y, 1);
    check("hold still_wait", state, WAIT);
    tick();
    check("hold to_idle", state, IDLE);
    check("hold segs_left", exp_q.size(), 0);
    en_mode = 0;
    lat_y   = 3;
    repeat (2) tick();

    // reset mid-WAIT aborts the move
    push_seg(75, -25, 4);
    send_cmd(300, -100);
    wait_state("abort", WAIT, 200);
    reset = 1'b0;
    #1;
    check("abort trigger", bus.trigger, 0);
    check("abort busy", bus.busy, 0);
    check("abort cmd_ready", bus.cmd_ready, 1);
    check("abort state", state, IDLE);
    check("abort seg", seg, 0);
    check("abort steps_x", bus.num_steps_x, 0);
    check("abort segs_left", exp_q.size(), 3);
    exp_q.delete();
    tick();
    reset = 1'b1;
    repeat (6) tick();
    push_seg(76, 3, 1);
    push_seg(75, 3, 1);
    push_seg(75, 2, 2);
    run_move("after_reset", 301, 10, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
